// File: rtl/de_ex_pipe.sv
// Decode-to-execute pipeline register with load-use hazard detection,
// branch flush, downstream hold and a saturating bubble counter.
module de_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_de,
    input  logic [XLEN-1:0]   pc_de,
    input  logic [4:0]        rs1_de,
    input  logic [4:0]        rs2_de,
    input  logic              uses_rs1_de,
    input  logic              uses_rs2_de,
    input  logic [4:0]        rd_de,
    input  logic [XLEN-1:0]   RUrs1_de,
    input  logic [XLEN-1:0]   RUrs2_de,
    input  logic [XLEN-1:0]   imm_de,
    input  logic [CTRL_W-1:0] ctrl_de,
    input  logic              RUWr_de,
    input  logic              DMRd_de,
    input  logic              DMWr_de,
    input  logic              flush_ex,
    input  logic              hold_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic [XLEN-1:0]   RUrs1_ex,
    output logic [XLEN-1:0]   RUrs2_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              valid_ex,
    output logic              RUWr_ex,
    output logic              DMRd_ex,
    output logic              DMWr_ex,
    output logic              stall_de,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]   rurs1_q, rurs1_d, rurs2_q, rurs2_d, imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d, ruwr_q, ruwr_d;
    logic              dmrd_q, dmrd_d, dmwr_q, dmwr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    // A load in EX whose destination feeds the decoding instruction; x0 never counts.
    always_comb begin
        hazard = valid_de & valid_q & dmrd_q & ruwr_q & (rd_q != 5'd0) &
                 ((uses_rs1_de & (rd_q == rs1_de)) | (uses_rs2_de & (rd_q == rs2_de)));
        stall_de = hold_ex | (hazard & ~flush_ex);
    end

    always_comb begin
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        rurs1_d = rurs1_q;
        rurs2_d = rurs2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        ruwr_d  = ruwr_q;
        dmrd_d  = dmrd_q;
        dmwr_d  = dmwr_q;
        cnt_d   = cnt_q;
        if (flush_ex || (!hold_ex && hazard)) begin
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            rurs1_d = '0;
            rurs2_d = '0;
            imm_d   = '0;
            ctrl_d  = '0;
            valid_d = 1'b0;
            ruwr_d  = 1'b0;
            dmrd_d  = 1'b0;
            dmwr_d  = 1'b0;
            // Only a real bubble is counted, not a flush.
            if (!flush_ex && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end else if (!hold_ex) begin
            pc_d    = pc_de;
            rs1_d   = rs1_de;
            rs2_d   = rs2_de;
            rd_d    = rd_de;
            rurs1_d = RUrs1_de;
            rurs2_d = RUrs2_de;
            imm_d   = imm_de;
            ctrl_d  = ctrl_de;
            valid_d = valid_de;
            ruwr_d  = RUWr_de & valid_de;
            dmrd_d  = DMRd_de & valid_de;
            dmwr_d  = DMWr_de & valid_de;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rurs1_q <= '0;
            rurs2_q <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            ruwr_q  <= 1'b0;
            dmrd_q  <= 1'b0;
            dmwr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            rurs1_q <= rurs1_d;
            rurs2_q <= rurs2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            ruwr_q  <= ruwr_d;
            dmrd_q  <= dmrd_d;
            dmwr_q  <= dmwr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_ex      = pc_q;
    assign rs1_ex     = rs1_q;
    assign rs2_ex     = rs2_q;
    assign rd_ex      = rd_q;
    assign RUrs1_ex   = rurs1_q;
    assign RUrs2_ex   = rurs2_q;
    assign imm_ex     = imm_q;
    assign ctrl_ex    = ctrl_q;
    assign valid_ex   = valid_q;
    assign RUWr_ex    = ruwr_q;
    assign DMRd_ex    = dmrd_q;
    assign DMWr_ex    = dmwr_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_de_ex_pipe.sv
// Directed bench for de_ex_pipe; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_de_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_de;
    logic [31:0] pc_de;
    logic [4:0]  rs1_de, rs2_de, rd_de;
    logic        uses_rs1_de, uses_rs2_de;
    logic [31:0] RUrs1_de, RUrs2_de, imm_de;
    logic [7:0]  ctrl_de;
    logic        RUWr_de, DMRd_de, DMWr_de, flush_ex, hold_ex;

    logic [31:0] pc_ex, RUrs1_ex, RUrs2_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [7:0]  ctrl_ex;
    logic        valid_ex, RUWr_ex, DMRd_ex, DMWr_ex, stall_de;
    logic [15:0] bubble_cnt;

    logic [31:0] s_pc_ex, s_RUrs1_ex, s_RUrs2_ex, s_imm_ex;
    logic [4:0]  s_rs1_ex, s_rs2_ex, s_rd_ex;
    logic [7:0]  s_ctrl_ex;
    logic        s_valid_ex, s_RUWr_ex, s_DMRd_ex, s_DMWr_ex, s_stall_de;
    logic [1:0]  s_bubble_cnt;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    de_ex_pipe dut (
        .clk(clk), .rst_n(rst_n), .valid_de(valid_de), .pc_de(pc_de),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .uses_rs1_de(uses_rs1_de),
        .uses_rs2_de(uses_rs2_de), .rd_de(rd_de), .RUrs1_de(RUrs1_de),
        .RUrs2_de(RUrs2_de), .imm_de(imm_de), .ctrl_de(ctrl_de),
        .RUWr_de(RUWr_de), .DMRd_de(DMRd_de), .DMWr_de(DMWr_de),
        .flush_ex(flush_ex), .hold_ex(hold_ex),
        .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .RUrs1_ex(RUrs1_ex), .RUrs2_ex(RUrs2_ex), .imm_ex(imm_ex),
        .ctrl_ex(ctrl_ex), .valid_ex(valid_ex), .RUWr_ex(RUWr_ex),
        .DMRd_ex(DMRd_ex), .DMWr_ex(DMWr_ex), .stall_de(stall_de),
        .bubble_cnt(bubble_cnt)
    );

    de_ex_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .valid_de(valid_de), .pc_de(pc_de),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .uses_rs1_de(uses_rs1_de),
        .uses_rs2_de(uses_rs2_de), .rd_de(rd_de), .RUrs1_de(RUrs1_de),
        .RUrs2_de(RUrs2_de), .imm_de(imm_de), .ctrl_de(ctrl_de),
        .RUWr_de(RUWr_de), .DMRd_de(DMRd_de), .DMWr_de(DMWr_de),
        .flush_ex(flush_ex), .hold_ex(hold_ex),
        .pc_ex(s_pc_ex), .rs1_ex(s_rs1_ex), .rs2_ex(s_rs2_ex), .rd_ex(s_rd_ex),
        .RUrs1_ex(s_RUrs1_ex), .RUrs2_ex(s_RUrs2_ex), .imm_ex(s_imm_ex),
        .ctrl_ex(s_ctrl_ex), .valid_ex(s_valid_ex), .RUWr_ex(s_RUWr_ex),
        .DMRd_ex(s_DMRd_ex), .DMWr_ex(s_DMWr_ex), .stall_de(s_stall_de),
        .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d: valid_ex=%0b pc_ex=0x%08h rd_ex=%0d DMRd_ex=%0b stall_de=%0b bubble_cnt=%0d",
                 cycle, valid_ex, pc_ex, rd_ex, DMRd_ex, stall_de, bubble_cnt);
    endtask

    // Decode-side instruction helper: rd, rs1, rs2, uses flags, load flag, pc.
    task automatic instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic ld, input logic [31:0] pc);
        valid_de = 1'b1; rd_de = rd; rs1_de = rs1; rs2_de = rs2;
        uses_rs1_de = u1; uses_rs2_de = u2; DMRd_de = ld; RUWr_de = 1'b1;
        DMWr_de = 1'b0; pc_de = pc;
    endtask

    initial begin
        // Reset with arbitrary decode inputs
        rst_n = 1'b0;
        valid_de = 1'b1; pc_de = 32'hDEAD_BEEF; rs1_de = 5'd6; rs2_de = 5'd7;
        uses_rs1_de = 1'b1; uses_rs2_de = 1'b1; rd_de = 5'd6;
        RUrs1_de = 32'h1234_5678; RUrs2_de = 32'h9ABC_DEF0; imm_de = 32'h55;
        ctrl_de = 8'hA5; RUWr_de = 1'b1; DMRd_de = 1'b1; DMWr_de = 1'b1;
        flush_ex = 1'b0; hold_ex = 1'b0;
        step(); step();
        chk("rst_valid_ex", valid_ex, 0);
        chk("rst_pc_ex", pc_ex, 0);
        chk("rst_rd_ex", rd_ex, 0);
        chk("rst_ctrl_ex", ctrl_ex, 0);
        chk("rst_RUWr_ex", RUWr_ex, 0);
        chk("rst_DMRd_ex", DMRd_ex, 0);
        chk("rst_stall_de", stall_de, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);

        // Pass-through after reset release
        rst_n = 1'b1;
        instr(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'h40);
        RUrs1_de = 32'h11; RUrs2_de = 32'h22; imm_de = 32'hFFFF_FFF0; ctrl_de = 8'h3C;
        chk("pt_stall_de", stall_de, 0);
        step();
        chk("pt_pc_ex", pc_ex, 32'h40);
        chk("pt_RUrs1_ex", RUrs1_ex, 32'h11);
        chk("pt_RUrs2_ex", RUrs2_ex, 32'h22);
        chk("pt_imm_ex", imm_ex, 32'hFFFF_FFF0);
        chk("pt_rd_ex", rd_ex, 5);
        chk("pt_rs1_ex", rs1_ex, 1);
        chk("pt_ctrl_ex", ctrl_ex, 8'h3C);
        chk("pt_RUWr_ex", RUWr_ex, 1);
        chk("pt_valid_ex", valid_ex, 1);

        // Invalid decode slot: enables qualified away, data still captured
        valid_de = 1'b0; DMRd_de = 1'b1; DMWr_de = 1'b1; pc_de = 32'h44;
        step();
        chk("q_valid_ex", valid_ex, 0);
        chk("q_RUWr_ex", RUWr_ex, 0);
        chk("q_DMRd_ex", DMRd_ex, 0);
        chk("q_DMWr_ex", DMWr_ex, 0);
        chk("q_pc_ex", pc_ex, 32'h44);

        // Load-use: lw x6 then add x7,x6,x1
        instr(5'd6, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'h48);
        step();
        chk("lu_lw_DMRd_ex", DMRd_ex, 1);
        instr(5'd7, 5'd6, 5'd1, 1'b1, 1'b1, 1'b0, 32'h4C);
        #1 chk("lu_stall_de", stall_de, 1);
        step();
        chk("lu_bubble_valid_ex", valid_ex, 0);
        chk("lu_bubble_pc_ex", pc_ex, 0);
        chk("lu_bubble_RUWr_ex", RUWr_ex, 0);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        chk("lu_stall_cleared", stall_de, 0);
        step();
        chk("lu_add_pc_ex", pc_ex, 32'h4C);
        chk("lu_add_rd_ex", rd_ex, 7);
        chk("lu_add_valid_ex", valid_ex, 1);
        chk("lu_cnt_after", bubble_cnt, 1);

        // lw x0 then use of x0: no stall
        instr(5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'h50);
        step();
        instr(5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h54);
        #1 chk("x0_stall_de", stall_de, 0);
        step();
        chk("x0_pc_ex", pc_ex, 32'h54);
        chk("x0_bubble_cnt", bubble_cnt, 1);

        // lw x6 then instr with rs2=6 but uses_rs2=0: no stall
        instr(5'd6, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'h58);
        step();
        instr(5'd9, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 32'h5C);
        #1 chk("rs2u_stall_de", stall_de, 0);
        step();
        chk("rs2u_pc_ex", pc_ex, 32'h5C);
        chk("rs2u_bubble_cnt", bubble_cnt, 1);

        // Hazard plus flush: flush wins, no stall, no count
        instr(5'd6, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'h60);
        step();
        instr(5'd7, 5'd6, 5'd1, 1'b1, 1'b1, 1'b0, 32'h64);
        flush_ex = 1'b1;
        #1 chk("fl_stall_de", stall_de, 0);
        step();
        chk("fl_valid_ex", valid_ex, 0);
        chk("fl_pc_ex", pc_ex, 0);
        chk("fl_rd_ex", rd_ex, 0);
        chk("fl_bubble_cnt", bubble_cnt, 1);
        flush_ex = 1'b0;

        // Hold for 3 cycles: EX frozen, stall asserted
        instr(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'h68);
        step();
        chk("hd_pc_ex_pre", pc_ex, 32'h68);
        hold_ex = 1'b1;
        instr(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'h6C);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hd_stall_de", stall_de, 1);
            step();
            chk("hd_pc_ex", pc_ex, 32'h68);
            chk("hd_rd_ex", rd_ex, 8);
            chk("hd_valid_ex", valid_ex, 1);
        end
        hold_ex = 1'b0;

        // Hold together with hazard: hold wins, hazard re-evaluated afterwards
        instr(5'd6, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'h70);
        step();
        hold_ex = 1'b1;
        instr(5'd7, 5'd6, 5'd1, 1'b1, 1'b1, 1'b0, 32'h74);
        step();
        chk("hh_pc_ex", pc_ex, 32'h70);
        chk("hh_DMRd_ex", DMRd_ex, 1);
        chk("hh_bubble_cnt", bubble_cnt, 1);
        hold_ex = 1'b0;
        #1 chk("hh_stall_hazard", stall_de, 1);
        step();
        chk("hh_bubble_valid", valid_ex, 0);
        chk("hh_bubble_cnt2", bubble_cnt, 2);
        chk("hh_sat_cnt2", s_bubble_cnt, 2);
        step();
        chk("hh_add_pc_ex", pc_ex, 32'h74);

        // Flush and hold together: flush clears EX
        hold_ex = 1'b1; flush_ex = 1'b1;
        #1 chk("fh_stall_de", stall_de, 1);
        step();
        chk("fh_valid_ex", valid_ex, 0);
        chk("fh_pc_ex", pc_ex, 0);
        chk("fh_RUWr_ex", RUWr_ex, 0);
        hold_ex = 1'b0; flush_ex = 1'b0;

        // Four more load-use pairs: 16-bit counter reaches 6, 2-bit saturates at 3
        for (int n = 3; n <= 6; n++) begin
            instr(5'd6, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'h80);
            step();
            instr(5'd7, 5'd2, 5'd6, 1'b0, 1'b1, 1'b0, 32'h84);
            step();
            chk("sat_wide_cnt", bubble_cnt, n);
            chk("sat_narrow_cnt", s_bubble_cnt, (n > 3) ? 3 : n);
            step();
            chk("sat_add_pc_ex", pc_ex, 32'h84);
        end

        // Reset mid-operation clears state immediately
        instr(5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'h90);
        step();
        chk("mr_pc_pre", pc_ex, 32'h90);
        rst_n = 1'b0;
        #1;
        chk("mr_valid_ex", valid_ex, 0);
        chk("mr_pc_ex", pc_ex, 0);
        chk("mr_bubble_cnt", bubble_cnt, 0);
        chk("mr_sat_cnt", s_bubble_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_after_release_pc", pc_ex, 32'h90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/de_ex_pipe.md
Name: de_ex_pipe

Overview:
- Decode-to-execute pipeline register of the 5-stage RISC-V core.
- Captures register-bank read data (RUrs1/RUrs2), immediate, PC and control from decode, and presents them to execute.
- Contains the load-use hazard detector: it stalls decode/fetch and inserts one bubble.
- Handles branch flush and external (memory-wait) hold.
- Keeps a saturating load-use bubble counter for performance debug.

Parameters:
- XLEN, 32, data/address width.
- CTRL_W, 8, width of opaque ALU/branch/mux control bundle passed through.
- CNT_W, 16, width of bubble counter.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- valid_de  in  1  decode holds a real instruction.
- pc_de  in  XLEN  decode PC.
- rs1_de  in  5  source reg 1 address (same value driven to register bank).
- rs2_de  in  5  source reg 2 address.
- uses_rs1_de  in  1  instruction reads rs1.
- uses_rs2_de  in  1  instruction reads rs2.
- rd_de  in  5  destination reg.
- RUrs1_de  in  XLEN  register bank read data 1.
- RUrs2_de  in  XLEN  register bank read data 2.
- imm_de  in  XLEN  decoded immediate.
- ctrl_de  in  CTRL_W  pass-through control.
- RUWr_de  in  1  writes register.
- DMRd_de  in  1  is a load.
- DMWr_de  in  1  is a store.
- flush_ex  in  1  branch/jump taken in execute: kill instruction entering EX.
- hold_ex  in  1  downstream not ready: freeze EX.
- pc_ex, rs1_ex, rs2_ex, rd_ex, RUrs1_ex, RUrs2_ex, imm_ex, ctrl_ex  out  (same widths)  registered copies.
- valid_ex, RUWr_ex, DMRd_ex, DMWr_ex  out  1  registered, qualified.
- stall_de  out  1  freeze PC and IF/DE register this cycle (combinational).
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (rst_n=0, asynchronous): all *_ex outputs 0, bubble_cnt 0. stall_de evaluates to 0, since valid_ex is 0.
- hazard = valid_de & valid_ex & DMRd_ex & RUWr_ex & (rd_ex!=0) & ((uses_rs1_de & rd_ex==rs1_de) | (uses_rs2_de & rd_ex==rs2_de)).
- stall_de = hold_ex | (hazard & ~flush_ex). Combinational, no registered latency.
- Posedge update, priority high to low:
  1. flush_ex: all *_ex cleared to 0, including valid and write enables. Flush beats hold and hazard.
  2. hold_ex: all *_ex keep their values.
  3. hazard: insert a bubble. All *_ex cleared to 0. bubble_cnt += 1, saturating at 2^CNT_W-1 (no wrap).
  4. otherwise: capture all *_de fields. Enables are qualified: valid_ex=valid_de, RUWr_ex=RUWr_de&valid_de, DMRd_ex=DMRd_de&valid_de, DMWr_ex=DMWr_de&valid_de.
- Latency: 1 cycle decode to EX. A load-use pair costs exactly 1 bubble, because the bubble has DMRd_ex=0 and the hazard clears the next cycle.
- rd_ex==0 never triggers a hazard. A load to x0 followed by use of x0 proceeds without a stall.
- Operand data is captured as-is. Register bank writes land on negedge, so a WB write in the same cycle is already visible at posedge capture. Forwarding from EX/MEM is a separate block.
- hold_ex and hazard together: hold wins. The counter does not increment and the hazard is re-evaluated the next cycle.
- Reset asserted mid-operation clears everything immediately. No instruction is retained.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all *_ex=0, stall_de=0, bubble_cnt=0. Release -> first valid instr appears on *_ex one cycle later.
- Pass-through: valid_de=1, pc_de=0x40, RUrs1_de=0x11, imm_de=0xFFFFFFF0, rd_de=5, RUWr_de=1 -> next cycle pc_ex=0x40, RUrs1_ex=0x11, imm_ex=0xFFFFFFF0, rd_ex=5, RUWr_ex=1.
- Load-use: lw x6 in EX, decode add x7,x6,x1 (uses_rs1) -> stall_de=1 for 1 cycle, bubble (valid_ex=0) enters EX, bubble_cnt=1. Add enters EX the following cycle, stall_de=0.
- No false hazard: lw x0, then use x0; or lw x6, then instr with uses_rs2_de=0 and rs2_de=6 -> stall_de=0, bubble_cnt unchanged.
- Flush priority: hazard condition plus flush_ex=1 -> stall_de=0, *_ex=0 next cycle, bubble_cnt unchanged. flush_ex and hold_ex together -> *_ex cleared.
- Hold and saturation: hold_ex=1 for 3 cycles -> *_ex stable, stall_de=1. With CNT_W=2, force 5 load-use bubbles -> bubble_cnt stops at 3.
